// File: rtl/sample_pipe_reg.sv
// sample_pipe_reg: elastic register pipeline of DEPTH stages with valid/ready
// handshaking on both sides, bubble collapsing, synchronous flush and an
// occupancy count of the stages currently holding a word.
// Optional build macro SAMPLE_PIPE_REG_CNT_EN adds a 32-bit out_cnt output
// that counts output transfers (wraps, reset to 0, unaffected by flush).

module sample_pipe_reg #(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef SAMPLE_PIPE_REG_CNT_EN
    ,
    output logic [31:0]                  out_cnt
`endif
);

    localparam int unsigned OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] stage_v;
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] src_d [DEPTH];
    logic             room_0;
    logic             in_fire;

    // Walk from the output back: a stage moves on if everything ahead of it
    // has a hole or the output is draining; a running "room" flag carries that.
    always_comb begin
        logic room;
        room = out_ready;
        adv  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            adv[k] = stage_v[k] && room;
            room   = room || !stage_v[k];
        end
        room_0 = room;
    end

    // Accept only outside reset and flush, and only when stage 0 frees up.
    always_comb begin
        in_ready = reset && !flush && room_0;
        in_fire  = in_valid && in_ready;
    end

    // Each stage loads from the one behind it; stage 0 loads from the input.
    always_comb begin
        load[0]  = in_fire;
        src_d[0] = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            load[k]  = adv[k-1];
            src_d[k] = stage_d[k-1];
        end
    end

    // Stage registers: load wins over leaving; flush drops valids, keeps data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                stage_d[k] <= RST_VAL;
            end
        end else if (flush) begin
            stage_v <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (load[k]) begin
                    stage_v[k] <= 1'b1;
                    stage_d[k] <= src_d[k];
                end else if (adv[k]) begin
                    stage_v[k] <= 1'b0;
                end
            end
        end
    end

    // Population count of the valid bits.
    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OCC_W'(stage_v[k]);
        end
    end

    assign out_valid = stage_v[DEPTH-1];
    assign out_data  = stage_d[DEPTH-1];

`ifdef SAMPLE_PIPE_REG_CNT_EN
    // Output transfer counter; a transfer on a flush edge still counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_cnt <= '0;
        end else if (out_valid && out_ready) begin
            out_cnt <= out_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sample_pipe_reg.sv
// Bench for sample_pipe_reg (WIDTH=8, DEPTH=4, RST_VAL=8'hA5).
// The reference model keeps the held words as a queue with each word's
// stage position; every edge a word moves one stage forward unless the word
// ahead of it blocks, and the head leaves from the last stage on out_ready.

module tb_sample_pipe_reg;

    localparam int          D  = 4;
    localparam logic [7:0]  RV = 8'hA5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_ready = 1'b0;
    logic       flush = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] occupancy;
`ifdef SAMPLE_PIPE_REG_CNT_EN
    logic [31:0] out_cnt;
`endif

    sample_pipe_reg #(.WIDTH(8), .DEPTH(D), .RST_VAL(RV)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .occupancy (occupancy)
`ifdef SAMPLE_PIPE_REG_CNT_EN
        ,
        .out_cnt   (out_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model state
    logic [7:0] md[$];
    int         mp[$];
    int         nxt[$];
    bit         pop_e;
    bit         room0;
    bit         exp_ir;
    logic [7:0] popped[$];
    int         cnt_e = 0;

    // DUT values captured at the last per-cycle compare
    logic       last_ov, last_ir;
    logic [7:0] last_od;
    logic [2:0] last_occ;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic calc_next(input bit ordy);
        int cap;
        int np;
        nxt.delete();
        cap   = D;
        pop_e = (mp.size() > 0) && (mp[0] == D - 1) && ordy;
        room0 = 1'b1;
        for (int i = 0; i < mp.size(); i++) begin
            if (i == 0 && pop_e) begin
                nxt.push_back(-1);
            end else begin
                np = (mp[i] + 1 < cap - 1) ? mp[i] + 1 : cap - 1;
                nxt.push_back(np);
                cap = np;
            end
            if (mp[i] == 0 && nxt[i] == 0) room0 = 1'b0;
        end
    endtask

    task automatic model_clear();
        md.delete();
        mp.delete();
        cnt_e = 0;
    endtask

    task automatic model_update(input bit fire, input logic [7:0] id, input bit fl);
        if (pop_e) begin
            popped.push_back(md[0]);
            cnt_e++;
        end
        if (fl) begin
            md.delete();
            mp.delete();
        end else begin
            for (int i = 0; i < mp.size(); i++) mp[i] = nxt[i];
            if (pop_e) begin
                void'(md.pop_front());
                void'(mp.pop_front());
            end
            if (fire) begin
                md.push_back(id);
                mp.push_back(0);
            end
        end
    endtask

    task automatic compare();
        bit eov;
        calc_next(out_ready);
        exp_ir = reset && !flush && room0;
        eov    = (mp.size() > 0) && (mp[0] == D - 1);
        last_ov  = out_valid;
        last_od  = out_data;
        last_occ = occupancy;
        last_ir  = in_ready;
        chk("out_valid", 32'(out_valid), 32'(eov));
        if (eov) chk("out_data", 32'(out_data), 32'(md[0]));
        chk("occupancy", 32'(occupancy), 32'(mp.size()));
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
`ifdef SAMPLE_PIPE_REG_CNT_EN
        chk("out_cnt", out_cnt, 32'(cnt_e));
`endif
    endtask

    task automatic step(input bit iv, input logic [7:0] id, input bit ordy, input bit fl);
        bit fire;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        compare();
        fire = iv && exp_ir;
        @(posedge clk);
        model_update(fire, id, fl);
    endtask

    task automatic stream_1_to_10();
        popped.delete();
        for (int s = 0; s < 16; s++) begin
            step(s < 10, 8'(s + 1), 1'b1, 1'b0);
            chk("stream_ov", 32'(last_ov), 32'((s >= 4) && (s < 14)));
            if (s >= 4 && s < 14) chk("stream_od", 32'(last_od), 32'(s - 3));
        end
        chk("stream_cnt", 32'(popped.size()), 32'd10);
    endtask

    initial begin
        // reset held low for 3 cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_od", 32'(out_data), 32'hA5);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_ir", 32'(in_ready), 32'd0);
`ifdef SAMPLE_PIPE_REG_CNT_EN
        chk("rst_cnt", out_cnt, 32'd0);
`endif
        reset = 1'b1;
        model_clear();
        #1;
        chk("rel_ir", 32'(in_ready), 32'd1);

        stream_1_to_10();

        // backpressure: 6 pushes, 4 fit
        popped.delete();
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step(1'b1, 8'h17, 1'b0, 1'b0);
        chk("bp_occ", 32'(last_occ), 32'd4);
        chk("bp_ir", 32'(last_ir), 32'd0);
        chk("bp_od", 32'(last_od), 32'h11);
        chk("bp_ov", 32'(last_ov), 32'd1);
        repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("bp_drain_n", 32'(popped.size()), 32'd4);
        for (int i = 0; i < 4 && i < popped.size(); i++)
            chk("bp_drain_d", 32'(popped[i]), 32'(8'h11 + i));

        // full pipe, streaming through
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'(8'h25 + i), 1'b1, 1'b0);
            chk("full_occ", 32'(last_occ), 32'd4);
            chk("full_ir", 32'(last_ir), 32'd1);
        end
        repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0);

        // flush with 3 held words
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("fl_ir", 32'(last_ir), 32'd0);
        popped.delete();
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        chk("fl_occ", 32'(last_occ), 32'd0);
        chk("fl_ov", 32'(last_ov), 32'd0);
        repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fl_alone_n", 32'(popped.size()), 32'd1);
        if (popped.size() > 0) chk("fl_alone_d", 32'(popped[0]), 32'h5A);

        // async reset with two words held, head at the output
        step(1'b1, 8'h41, 1'b0, 1'b0);
        step(1'b1, 8'h42, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("pre_rst_occ", 32'(occupancy), 32'd2);
        chk("pre_rst_ov", 32'(out_valid), 32'd1);
        #1;
        reset = 1'b0;
        model_clear();
        #1;
        chk("arst_ov", 32'(out_valid), 32'd0);
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_od", 32'(out_data), 32'hA5);
        chk("arst_ir", 32'(in_ready), 32'd0);
`ifdef SAMPLE_PIPE_REG_CNT_EN
        chk("arst_cnt", out_cnt, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_rel_ir", 32'(in_ready), 32'd1);
`ifdef SAMPLE_PIPE_REG_CNT_EN
        stream_1_to_10();
        chk("cnt_after_stream", out_cnt, 32'd10);
`endif

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 19) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_pipe_reg.md
SAMPLE_PIPE_REG -- requirements
Module: sample_pipe_reg

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 Parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 Parameter RST_VAL, default 0, WIDTH-bit value loaded into every data stage at reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 in_valid  input  1  upstream data valid.
REQ-007 in_ready  output  1  block can accept in_data this cycle.
REQ-008 in_data  input  WIDTH  upstream data.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  WIDTH  data of the last stage.
REQ-012 flush  input  1  synchronous discard of all held words.
REQ-013 occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-014 Block SHALL be an elastic pipeline of DEPTH stages, each holding a valid bit and a WIDTH-bit data register; stage DEPTH-1 drives out_valid/out_data.
REQ-015 Input transfer SHALL occur when in_valid && in_ready at a rising edge; output transfer when out_valid && out_ready.
REQ-016 Stage k SHALL advance when stage k+1 is empty or stage k+1 advances in the same cycle; last stage advances on output transfer (bubble collapsing).
REQ-017 in_ready SHALL be 1 when stage 0 is empty or stage 0 advances this cycle, and 0 while flush=1.
REQ-018 With out_ready held 1 and no bubbles, a word accepted at edge N SHALL appear on out_valid/out_data after edge N+DEPTH-1 (latency DEPTH cycles counting the accept edge), throughput one word per cycle.
REQ-019 Words SHALL leave in acceptance order; none duplicated or dropped except by flush/reset.
REQ-020 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 When all DEPTH stages are valid and out_ready=0, in_ready SHALL be 0; with out_ready=1 in the same state, simultaneous input and output transfer SHALL occur.
REQ-022 occupancy SHALL equal the count of valid stages after each edge; range 0..DEPTH, no wrap.
REQ-023 flush=1 at an edge SHALL clear all valid bits; no input accepted that edge; output transfer that edge still counts if out_valid&&out_ready; data registers keep their contents.
REQ-024 in_valid/in_data SHALL be don't-care when in_ready=0; out_ready is don't-care when out_valid=0.

Reset
REQ-025 While reset=0, all valid bits SHALL be 0 immediately (asynchronously), all data registers RST_VAL, out_valid=0, out_data=RST_VAL, occupancy=0, in_ready=0.
REQ-026 Reset asserted mid-transfer SHALL discard all held words; first edge after reset=1 SHALL accept input (in_ready=1).

Configuration
REQ-027 Macro SAMPLE_PIPE_REG_CNT_EN defined: extra output out_cnt (32 bits) SHALL count output transfers, reset to 0, wrap 0xFFFFFFFF->0, unaffected by flush.
REQ-028 Macro undefined: out_cnt port and counter SHALL not exist; all other behaviour identical.

Verification (WIDTH=8, DEPTH=4, RST_VAL=8'hA5)
REQ-029 Reset pulse reset=0 for 3 cycles -> out_valid=0, out_data=8'hA5, occupancy=0; after release in_ready=1.
REQ-030 Stream 0x01..0x0A, in_valid=1, out_ready=1 -> outputs 0x01..0x0A in order on consecutive cycles, first 4 cycles after first accept.
REQ-031 out_ready=0, push 6 words -> 4 accepted, in_ready=0, occupancy=4, out_data=first word stable; then out_ready=1 -> remaining words drain in order.
REQ-032 Pipe full with out_ready=1 and in_valid=1 -> one in and one out per cycle, occupancy stays 4.
REQ-033 3 words held, flush=1 one cycle -> occupancy=0, out_valid=0 next cycle; next pushed word 0x5A emerges alone.
REQ-034 reset=0 asserted between edges with occupancy=2 -> out_valid=0 immediately; with SAMPLE_PIPE_REG_CNT_EN, out_cnt=0 and counts 10 after REQ-030 stream.
